// File: rtl/stream_pkg.sv
// Shared definitions for the stream arbitration mux: arbitration mode
// constants and the grant-to-index encoder.
package stream_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int MAX_CH    = 64;

  // OR of set-bit positions; exact for one-hot input, 0 for an empty grant.
  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: fixed priority (lowest index) or
// round-robin search starting at the supplied pointer.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int SEL_W    = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (ARB_MODE == ARB_RR) idx = (int'(ptr) + i) % NUM_IN;
      else                    idx = i;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 valid/ready stream mux with manual select, fixed or round-robin
// arbitration and a single registered output stage.
module stream_arb_mux
  import stream_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_IN   = 4,
  parameter  int ARB_MODE = ARB_FIXED,
  localparam int SEL_W    = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]       in_valid_i,
  output logic [NUM_IN-1:0]       in_ready_o,
  input  logic                    man_en_i,
  input  logic [SEL_W-1:0]        man_sel_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SEL_W-1:0]        out_sel_o
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] arb_grant;
  logic [NUM_IN-1:0] man_grant;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load_en;
  logic              handshake;

  rr_arbiter #(
    .NUM_IN   (NUM_IN),
    .ARB_MODE (ARB_MODE),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req   (in_valid_i),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  // An out-of-range manual select matches no channel and so grants nothing.
  always_comb begin
    man_grant = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      man_grant[k] = in_valid_i[k] && (int'(man_sel_i) == k);
    end
  end

  assign grant      = man_en_i ? man_grant : arb_grant;
  assign grant_idx  = SEL_W'(onehot_to_idx(MAX_CH'(grant)));
  assign load_en    = !out_valid_o || out_ready_i;
  assign in_ready_o = load_en ? grant : '0;
  assign handshake  = |(in_valid_i & in_ready_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_sel_o   <= '0;
      rr_ptr      <= '0;
    end else if (handshake) begin
      out_valid_o <= 1'b1;
      out_data_o  <= in_data_i[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_o   <= grant_idx;
      if (ARB_MODE == ARB_RR && !man_en_i) begin
        rr_ptr <= SEL_W'((int'(grant_idx) + 1) % NUM_IN);
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: one fixed-priority and one round-robin
// instance share the same stimulus.
module tb_stream_arb_mux;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic                    man_en;
  logic [SEL_W-1:0]        man_sel;
  logic                    out_ready;

  logic [NUM_IN-1:0] fx_ready, rr_ready;
  logic [WIDTH-1:0]  fx_data,  rr_data;
  logic              fx_valid, rr_valid;
  logic [SEL_W-1:0]  fx_sel,   rr_sel;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_i = ~clk_i;

  stream_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .ARB_MODE(0)) dut_fx (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(fx_ready), .man_en_i(man_en), .man_sel_i(man_sel),
    .out_data_o(fx_data), .out_valid_o(fx_valid), .out_ready_i(out_ready),
    .out_sel_o(fx_sel)
  );

  stream_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .ARB_MODE(1)) dut_rr (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rr_ready), .man_en_i(man_en), .man_sel_i(man_sel),
    .out_data_o(rr_data), .out_valid_o(rr_valid), .out_ready_i(out_ready),
    .out_sel_o(rr_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [3:0] exp_oh;
    rst_ni    = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    man_en    = 1'b0;
    man_sel   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_ni = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", 32'(fx_valid), 32'd0);
      chk("idle_ready", 32'(fx_ready), 32'd0);
      chk("idle_data",  32'(fx_data),  32'd0);
      chk("idle_rr_valid", 32'(rr_valid), 32'd0);
    end
    chk("idle_sel", 32'(fx_sel), 32'd0);

    // fixed priority: ch1 beats ch3 while both valid
    in_data   = {8'h33, 8'h00, 8'h11, 8'h00};
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #1;
    chk("fp_ready_ch1", 32'(fx_ready), 32'b0010);
    step();
    chk("fp_data_ch1",  32'(fx_data),  32'h11);
    chk("fp_sel_ch1",   32'(fx_sel),   32'd1);
    chk("fp_valid_ch1", 32'(fx_valid), 32'd1);
    chk("fp_ready_hold", 32'(fx_ready), 32'b0010);
    step();
    chk("fp_sel_ch1_again", 32'(fx_sel), 32'd1);
    in_valid = 4'b1000;
    #1;
    chk("fp_ready_ch3", 32'(fx_ready), 32'b1000);
    step();
    chk("fp_data_ch3", 32'(fx_data), 32'h33);
    chk("fp_sel_ch3",  32'(fx_sel),  32'd3);
    in_valid = 4'b0000;
    step();
    chk("fp_drain_valid", 32'(fx_valid), 32'd0);
    chk("fp_drain_data",  32'(fx_data),  32'h33);
    chk("fp_drain_sel",   32'(fx_sel),   32'd3);

    // round-robin with all channels valid; pointer is back at 0 after ch3
    in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    in_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int e;
      e = n % 4;
      #1;
      exp_oh = 4'b0001 << e;
      chk("rr_ready", 32'(rr_ready), 32'(exp_oh));
      chk("fp_ready_all", 32'(fx_ready), 32'b0001);
      step();
      chk("rr_sel",   32'(rr_sel),   32'(e));
      chk("rr_valid", 32'(rr_valid), 32'd1);
      chk("rr_data",  32'(rr_data),  32'hD0 + 32'(e));
    end

    // backpressure: rr register holds ch1 beat, pointer at 2
    out_ready = 1'b0;
    #1;
    chk("bp_ready_off", 32'(rr_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rr_valid), 32'd1);
      chk("bp_data",  32'(rr_data),  32'hD1);
      chk("bp_ready", 32'(rr_ready), 32'd0);
      chk("bp_fx_ready", 32'(fx_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rr_ready), 32'b0100);
    step();
    chk("bp_next_data", 32'(rr_data), 32'hD2);
    chk("bp_next_sel",  32'(rr_sel),  32'd2);
    in_valid = 4'b0000;
    step();
    chk("bp_drain_valid", 32'(rr_valid), 32'd0);

    // manual select; rr pointer now 3 and must not move during manual transfers
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h5A};
    in_valid = 4'b0101;
    man_en   = 1'b1;
    man_sel  = 2'd2;
    #1;
    chk("man_fx_ready", 32'(fx_ready), 32'b0100);
    chk("man_rr_ready", 32'(rr_ready), 32'b0100);
    step();
    chk("man_data", 32'(fx_data), 32'hA5);
    chk("man_sel",  32'(fx_sel),  32'd2);
    man_sel = 2'd3;
    #1;
    chk("man_idle_ready", 32'(fx_ready), 32'd0);
    chk("man_idle_rr_ready", 32'(rr_ready), 32'd0);
    step();
    chk("man_idle_valid", 32'(fx_valid), 32'd0);
    chk("man_idle_data",  32'(fx_data),  32'hA5);
    man_sel = 2'd0;
    #1;
    chk("man_ch0_ready", 32'(rr_ready), 32'b0001);
    step();
    chk("man_ch0_data", 32'(rr_data), 32'h5A);
    man_en   = 1'b0;
    in_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    in_valid = 4'b1111;
    #1;
    chk("rr_ptr_kept", 32'(rr_ready), 32'b1000);
    step();
    chk("rr_after_man_sel", 32'(rr_sel), 32'd3);
    #1;
    chk("rr_wrap_ready", 32'(rr_ready), 32'b0001);
    step();
    chk("rr_wrap_sel", 32'(rr_sel), 32'd0);

    // async reset mid-stream; pointer was 1, must restart at 0
    rst_ni = 1'b0;
    #1;
    chk("rst_rr_valid", 32'(rr_valid), 32'd0);
    chk("rst_fx_valid", 32'(fx_valid), 32'd0);
    chk("rst_rr_data",  32'(rr_data),  32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    chk("rst_rr_ready", 32'(rr_ready), 32'b0001);
    step();
    chk("rst_rr_sel",  32'(rr_sel),  32'd0);
    chk("rst_rr_data2", 32'(rr_data), 32'hD0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
